// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- constants shared by the multiply/divide unit and the pipeline
// control blocks (Controller, HazardUnit).
//
// Contents:
//   MDU_* op encodings   3-bit operation codes presented on mult_div_unit.op
//   MUL_LAT / DIV_LAT    busy latency, in cycles, for multiply and divide
//   mdu_state_e          IDLE/RUN sequencing states
//   is_mul_op()          op decode helper
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  // Wide enough to hold the longest latency.
  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] MUL_LAT = 4'd5;
  localparam logic [CNT_W-1:0] DIV_LAT = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit -- multi-cycle multiply/divide unit owning the HI/LO registers.
//
// A MULT/MULTU/DIV/DIVU accepted in IDLE captures its operands, runs for a fixed
// latency (MUL_LAT / DIV_LAT) with busy high, then commits the result to HI/LO
// on the edge that busy falls. MTHI/MTLO write HI/LO directly in one cycle.
// Requests arriving while busy are ignored; the hazard unit stalls them.
//
// Configuration:
//   MULT_DIV_UNIT_DIV_EN  defined   -> DIV/DIVU implemented
//                         undefined -> DIV/DIVU are no-ops, no divider built
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous active-low reset
//   start  in   1   E-stage instruction is an MDU op
//   op     in   3   MDU_* operation code (mdu_pkg)
//   src_a  in  32   forwarded rs operand
//   src_b  in  32   forwarded rt operand
//   busy   out  1   operation in progress (registered)
//   hi     out 32   architectural HI
//   lo     out 32   architectural LO
// -----------------------------------------------------------------------------
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  import mdu_pkg::*;

  mdu_state_e       r_state;
  mdu_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_load;

  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [2:0]       r_op;

  logic [31:0]      r_res_hi;
  logic [31:0]      r_res_lo;
  logic             r_res_wr;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_res_wr;

  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0]      w_prod_s;
  logic [63:0]      w_prod_u;

  logic             w_is_div;
  logic             w_commit;

`ifdef MULT_DIV_UNIT_DIV_EN
  assign w_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
`else
  assign w_is_div = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && is_mul_op(op)) begin
          w_state_next = ST_RUN;
          w_cnt_next   = MUL_LAT;
          w_load       = 1'b1;
        end else if (start && w_is_div) begin
          w_state_next = ST_RUN;
          w_cnt_next   = DIV_LAT;
          w_load       = 1'b1;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here.
        if (r_cnt <= 1) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Final RUN cycle: the result is committed on the edge that busy falls.
  assign w_commit = (r_state == ST_RUN) && (r_cnt == 1);

  // ---------------------------------------------------------------------------
  // Arithmetic on the captured operands
  // ---------------------------------------------------------------------------
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_wr = 1'b0;
    case (r_op)
      MDU_MULT: begin
        {w_res_hi, w_res_lo} = w_prod_s;
        w_res_wr             = 1'b1;
      end
      MDU_MULTU: begin
        {w_res_hi, w_res_lo} = w_prod_u;
        w_res_wr             = 1'b1;
      end
`ifdef MULT_DIV_UNIT_DIV_EN
      // A zero divisor still runs the full latency but never commits.
      MDU_DIV: begin
        if (r_b != 32'd0) begin
          w_res_lo = $signed(r_a) / $signed(r_b);
          w_res_hi = $signed(r_a) % $signed(r_b);
          w_res_wr = 1'b1;
        end
      end
      MDU_DIVU: begin
        if (r_b != 32'd0) begin
          w_res_lo = r_a / r_b;
          w_res_hi = r_a % r_b;
          w_res_wr = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // NOTE: operand and shadow registers carry no reset; they are always written
  // before being read, and the commit path is gated by the reset FSM state.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_a  <= src_a;
      r_b  <= src_b;
      r_op <= op;
    end
    // Shadow result settles during the first RUN cycle; latency >= 2 ensures
    // it is stable by the commit edge.
    if (r_state == ST_RUN) begin
      r_res_hi <= w_res_hi;
      r_res_lo <= w_res_lo;
      r_res_wr <= w_res_wr;
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (r_res_wr) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
    end else if (r_state == ST_IDLE && start) begin
      if (op == MDU_MTHI) r_hi <= src_a;
      if (op == MDU_MTLO) r_lo <= src_a;
    end
  end

  assign busy = (r_state == ST_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit -- directed bench for mult_div_unit with an arithmetic
// reference model and a per-cycle compare process. Expected DIV/DIVU
// behaviour follows MULT_DIV_UNIT_DIV_EN exactly as the DUT is built.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_pass  = 0;
  int n_total = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an accepted op finishes a fixed number of cycles later.
  // ---------------------------------------------------------------------------
  int          m_cyc = 0;
  bit          m_valid = 0;
  bit          m_pending = 0;
  int          m_done_cyc = 0;
  bit          m_pend_wr = 0;
  logic [31:0] m_pend_hi, m_pend_lo;
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(posedge clk) begin
    longint p;
    int     q, r;
    m_cyc++;
    if (!reset) begin
      m_valid   = 1;
      m_pending = 0;
      m_hi      = '0;
      m_lo      = '0;
    end else if (m_pending) begin
      if (m_cyc == m_done_cyc) begin
        m_pending = 0;
        if (m_pend_wr) begin
          m_hi = m_pend_hi;
          m_lo = m_pend_lo;
        end
      end
    end else if (start) begin
      case (op)
        MDU_MULT: begin
          p = longint'($signed(src_a)) * longint'($signed(src_b));
          {m_pend_hi, m_pend_lo} = p;
          m_pend_wr = 1; m_pending = 1; m_done_cyc = m_cyc + 5;
        end
        MDU_MULTU: begin
          {m_pend_hi, m_pend_lo} = {32'd0, src_a} * {32'd0, src_b};
          m_pend_wr = 1; m_pending = 1; m_done_cyc = m_cyc + 5;
        end
`ifdef MULT_DIV_UNIT_DIV_EN
        MDU_DIV: begin
          m_pend_wr = (src_b != 0);
          if (m_pend_wr) begin
            q = $signed(src_a) / $signed(src_b);
            r = $signed(src_a) % $signed(src_b);
            m_pend_lo = q;
            m_pend_hi = r;
          end
          m_pending = 1; m_done_cyc = m_cyc + 10;
        end
        MDU_DIVU: begin
          m_pend_wr = (src_b != 0);
          if (m_pend_wr) begin
            m_pend_lo = src_a / src_b;
            m_pend_hi = src_a % src_b;
          end
          m_pending = 1; m_done_cyc = m_cyc + 10;
        end
`endif
        MDU_MTHI: m_hi = src_a;
        MDU_MTLO: m_lo = src_a;
        default: ;
      endcase
    end
  end

  // Compare process: outputs are meaningful on every cycle after reset is seen.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", {31'd0, busy}, {31'd0, m_pending});
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7));
    src_a = $urandom; src_b = $urandom;
  endtask

  // Count busy cycles following an accept; returns at a negedge with busy low.
  task automatic busy_cycles(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  int nb;

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // Signed multiply of -1 by 2.
    issue(MDU_MULT, 32'hFFFFFFFF, 32'd2);
    busy_cycles(nb);
    check("mult_busy_len", nb, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    // Same operands, unsigned.
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
    busy_cycles(nb);
    check("multu_busy_len", nb, 32'd5);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    // -7 / 2 signed, then 7 / 2 unsigned.
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    busy_cycles(nb);
`ifdef MULT_DIV_UNIT_DIV_EN
    check("div_busy_len", nb, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
`else
    check("div_off_busy", nb, 32'd0);
    check("div_off_hi", hi, 32'h00000001);
    check("div_off_lo", lo, 32'hFFFFFFFE);
`endif
    issue(MDU_DIVU, 32'd7, 32'd2);
    busy_cycles(nb);
`ifdef MULT_DIV_UNIT_DIV_EN
    check("divu_busy_len", nb, 32'd10);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);
`else
    check("divu_off_busy", nb, 32'd0);
    check("divu_off_hi", hi, 32'h00000001);
    check("divu_off_lo", lo, 32'hFFFFFFFE);
`endif

    // MTHI visible next cycle, then divide by zero keeps HI.
    issue(MDU_MTHI, 32'h12345678, 32'd0);
    @(negedge clk);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(MDU_DIV, 32'd100, 32'd0);
    busy_cycles(nb);
`ifdef MULT_DIV_UNIT_DIV_EN
    check("div0_busy_len", nb, 32'd10);
`else
    check("div0_off_busy", nb, 32'd0);
`endif
    check("div0_hi", hi, 32'h12345678);

    // MTLO, then unrecognised ops are no-ops.
    issue(MDU_MTLO, 32'h00000055, 32'd0);
    @(negedge clk);
    check("mtlo_lo", lo, 32'h00000055);
    issue(3'd6, 32'hDEADBEEF, 32'd3);
    issue(3'd7, 32'hCAFEF00D, 32'd3);
    @(negedge clk);
    check("badop_hi", hi, 32'h12345678);
    check("badop_lo", lo, 32'h00000055);

    // MULT 3 * -4; an MTLO on busy cycle 2 must be ignored.
    issue(MDU_MULT, 32'd3, 32'hFFFFFFFC);
    @(posedge clk); #1;
    start = 1'b1; op = MDU_MTLO; src_a = 32'h0000AAAA;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cycles(nb);
    check("mtlo_ignored_busy", nb, 32'd3);
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'hFFFFFFF4);

    // Reset on busy cycle 3 discards the in-flight result.
    issue(MDU_MULT, 32'h00010000, 32'h00010000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);

    // Start is ignored while reset is low.
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b1; op = MDU_MTHI; src_a = 32'h77777777;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    check("start_in_reset_hi", hi, 32'd0);

    // Full-width unsigned product after reset.
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    busy_cycles(nb);
    check("multu_max_hi", hi, 32'hFFFFFFFE);
    check("multu_max_lo", lo, 32'h00000001);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
